// File: rtl/shift_add_mult_if.sv
// shift_add_mult_if: operand/result valid-ready bundle for shift_add_mult_seq; signed_mode exists only under SHIFT_ADD_SIGNED_EN
interface shift_add_mult_if #(parameter int M = 8, parameter int N = 8);
  logic in_valid;
  logic in_ready;
  logic [M-1:0] A;
  logic [N-1:0] B;
  logic out_valid;
  logic out_ready;
  logic [M+N-1:0] C;
`ifdef SHIFT_ADD_SIGNED_EN
  logic signed_mode;
  modport master (output in_valid, A, B, out_ready, signed_mode, input in_ready, out_valid, C);
  modport slave (input in_valid, A, B, out_ready, signed_mode, output in_ready, out_valid, C);
`else
  modport master (output in_valid, A, B, out_ready, input in_ready, out_valid, C);
  modport slave (input in_valid, A, B, out_ready, output in_ready, out_valid, C);
`endif
endinterface

// File: rtl/shift_add_mult_seq.sv
// shift_add_mult_seq: iterative shift-and-add M x N multiplier, one B bit per clock; SHIFT_ADD_SIGNED_EN adds two's-complement mode
module shift_add_mult_seq #(
  parameter int M = 8,
  parameter int N = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input logic clk,
  input logic rst,
  shift_add_mult_if.slave io
);
  localparam int W = M + N;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] acc, a_sh, acc_n, a_ext;
  logic [N-1:0] b_sh;
  logic [CW-1:0] cnt;
  logic last, fin, sub;
`ifdef SHIFT_ADD_SIGNED_EN
  logic sgn;
  assign a_ext = io.signed_mode ? {{N{io.A[M-1]}}, io.A} : {{N{1'b0}}, io.A};
  // the final multiplier bit carries negative weight in two's complement
  assign sub = sgn && last;
`else
  assign a_ext = {{N{1'b0}}, io.A};
  assign sub = 1'b0;
`endif
  assign last = cnt == CW'(N - 1);
  assign fin = last || (EARLY_EXIT && (b_sh >> 1) == '0);
  assign acc_n = !b_sh[0] ? acc : sub ? acc - a_sh : acc + a_sh;
  assign io.in_ready = state == IDLE;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (io.in_valid ? RUN : IDLE)
            : state == RUN ? (fin ? DONE : RUN)
            : (io.out_valid && io.out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      acc <= '0;
      a_sh <= '0;
      b_sh <= '0;
      cnt <= '0;
      io.out_valid <= 1'b0;
      io.C <= '0;
`ifdef SHIFT_ADD_SIGNED_EN
      sgn <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (state == IDLE && io.in_valid) begin
        acc <= '0;
        a_sh <= a_ext;
        b_sh <= io.B;
        cnt <= '0;
`ifdef SHIFT_ADD_SIGNED_EN
        sgn <= io.signed_mode;
`endif
      end
      if (state == RUN) begin
        acc <= acc_n;
        a_sh <= a_sh << 1;
        b_sh <= b_sh >> 1;
        cnt <= cnt + CW'(1);
      end
      // first DONE cycle captures the product; out_valid follows one edge after RUN ends
      if (state == DONE) begin
        if (!io.out_valid) begin
          io.C <= acc;
          io.out_valid <= 1'b1;
        end else if (io.out_ready) begin
          io.out_valid <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_shift_add_mult_seq.sv
// tb_shift_add_mult_seq: runs early-exit and full-iteration instances side by side against an arithmetic reference
module tb_shift_add_mult_seq;
  localparam int M = 8;
  localparam int N = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  shift_add_mult_if #(.M(M), .N(N)) if1 ();
  shift_add_mult_if #(.M(M), .N(N)) if0 ();
  shift_add_mult_seq #(.M(M), .N(N), .EARLY_EXIT(1'b1)) dut1 (.clk(clk), .rst(rst), .io(if1));
  shift_add_mult_seq #(.M(M), .N(N), .EARLY_EXIT(1'b0)) dut0 (.clk(clk), .rst(rst), .io(if0));
  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b);
    if1.in_valid = v;
    if0.in_valid = v;
    if1.A = a;
    if0.A = a;
    if1.B = b;
    if0.B = b;
  endtask
  task automatic set_ready(input logic r);
    if1.out_ready = r;
    if0.out_ready = r;
  endtask
  function automatic int run_len(input logic [7:0] b);
    int r = 1;
    for (int i = 0; i < 8; i++) if (b[i]) r = i + 1;
    return r;
  endfunction
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hold);
    int l1 = -1;
    int l0 = -1;
    logic busy_bad = 1'b0;
    logic [15:0] exp = 16'({8'b0, a} * {8'b0, b});
    total++;
    if (!(if1.in_ready && if0.in_ready)) begin
      bad++;
      $display("FAIL accept_ready a=%0d b=%0d got %b/%b want 1/1", a, b, if1.in_ready, if0.in_ready);
    end
    drive(1'b1, a, b);
    @(posedge clk);
    #1;
    for (int c = 1; c <= 40 && (l1 < 0 || l0 < 0); c++) begin
      drive(1'($urandom), 8'($urandom), 8'($urandom));
      if ((l1 < 0 && if1.in_ready) || (l0 < 0 && if0.in_ready)) busy_bad = 1'b1;
      @(posedge clk);
      #1;
      if (l1 < 0 && if1.out_valid) l1 = c;
      if (l0 < 0 && if0.out_valid) l0 = c;
    end
    drive(1'b0, 8'($urandom), 8'($urandom));
    total++;
    if (busy_bad) begin
      bad++;
      $display("FAIL busy_ready a=%0d b=%0d got in_ready=1 want 0", a, b);
    end
    total++;
    if (l1 != run_len(b) + 1) begin
      bad++;
      $display("FAIL latency_ee a=%0d b=%0d got %0d want %0d", a, b, l1, run_len(b) + 1);
    end
    total++;
    if (l0 != N + 1) begin
      bad++;
      $display("FAIL latency_full a=%0d b=%0d got %0d want %0d", a, b, l0, N + 1);
    end
    total++;
    if (if1.C !== exp || if0.C !== exp) begin
      bad++;
      $display("FAIL product a=%0d b=%0d got %0d/%0d want %0d", a, b, if1.C, if0.C, exp);
    end
    for (int h = 0; h < hold; h++) begin
      drive(1'($urandom), 8'($urandom), 8'($urandom));
      @(posedge clk);
      #1;
      total++;
      if (if1.out_valid !== 1'b1 || if0.out_valid !== 1'b1 || if1.in_ready !== 1'b0 ||
          if0.in_ready !== 1'b0 || if1.C !== exp || if0.C !== exp) begin
        bad++;
        $display("FAIL hold cycle=%0d got v=%b%b r=%b%b C=%0d/%0d want v=11 r=00 C=%0d", h,
                 if1.out_valid, if0.out_valid, if1.in_ready, if0.in_ready, if1.C, if0.C, exp);
      end
    end
    drive(1'b0, 8'($urandom), 8'($urandom));
    set_ready(1'b1);
    @(posedge clk);
    #1;
    set_ready(1'b0);
    total++;
    if (if1.out_valid !== 1'b0 || if0.out_valid !== 1'b0 || if1.in_ready !== 1'b1 ||
        if0.in_ready !== 1'b1 || if1.C !== exp || if0.C !== exp) begin
      bad++;
      $display("FAIL release got v=%b%b r=%b%b C=%0d/%0d want v=00 r=11 C=%0d",
               if1.out_valid, if0.out_valid, if1.in_ready, if0.in_ready, if1.C, if0.C, exp);
    end
  endtask
  task automatic check_reset_state(input string tag);
    total++;
    if (if1.in_ready !== 1'b1 || if0.in_ready !== 1'b1 || if1.out_valid !== 1'b0 ||
        if0.out_valid !== 1'b0 || if1.C !== 16'd0 || if0.C !== 16'd0) begin
      bad++;
      $display("FAIL %s got r=%b%b v=%b%b C=%0d/%0d want r=11 v=00 C=0", tag,
               if1.in_ready, if0.in_ready, if1.out_valid, if0.out_valid, if1.C, if0.C);
    end
  endtask
  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b1;
  endtask
  task automatic test_directed();
    run_op(8'd12, 8'd63, 0);
    run_op(8'd255, 8'd255, 0);
    run_op(8'd255, 8'd1, 0);
    run_op(8'd200, 8'd0, 0);
    run_op(8'd1, 8'd128, 0);
  endtask
  task automatic test_hold();
    run_op(8'd77, 8'd19, 5);
  endtask
  task automatic test_reset_mid();
    drive(1'b1, 8'd200, 8'd255);
    @(posedge clk);
    #1;
    drive(1'b0, 8'd0, 8'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_reset_state("reset_mid");
    rst = 1'b1;
    run_op(8'd3, 8'd4, 0);
  endtask
  task automatic test_random();
    for (int k = 0; k < 30; k++) run_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
  endtask
  task automatic test_back_to_back();
    run_op(8'd255, 8'd128, 0);
    run_op(8'd5, 8'd2, 0);
    run_op(8'd0, 8'd255, 0);
  endtask
  initial begin
    drive(1'b0, 8'd0, 8'd0);
    set_ready(1'b0);
`ifdef SHIFT_ADD_SIGNED_EN
    if1.signed_mode = 1'b0;
    if0.signed_mode = 1'b0;
`endif
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
